barrel_rotate_pipe: RTL and testbench
=====================================

Name: barrel_rotate_pipe

Overview:
- Parametrised, pipelined rotate/shift unit for WIDTH-bit words.
- Supports rotate-left, rotate-right, logical shift-left and arithmetic shift-right.
- Rotate amounts of any size are handled, including zero and amounts of WIDTH or more.
- Sits in the datapath behind a valid/ready producer; one operation accepted per cycle, results in order after a fixed latency, with full backpressure.

Parameters:
- WIDTH, 32, data width; power of two, >= 4.
- AMT_W, 32, width of the amount port; >= clog2(WIDTH).
- SHW (localparam), clog2(WIDTH), number of pipeline stages; also the latency.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept input this cycle.
- in_x  in  WIDTH  operand.
- in_k  in  AMT_W  shift/rotate amount (unsigned).
- in_op  in  2  operation: 00 ROL, 01 ROR, 10 SLL, 11 SRA.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_o  out  WIDTH  result.
- out_oob  out  1  in_k was >= WIDTH, for any op.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, out_valid 0, out_o 0, out_oob 0. Operations in flight are discarded, not completed.
- Pipeline has SHW register stages. Stage i applies a rotate/shift by 2^i when the effective amount bit i is set.
- Last stage register drives out_o, out_valid and out_oob.
- advance = !out_valid | out_ready. All stages move together when advance=1 and all hold when advance=0 (global stall).
- in_ready = advance, combinational from out_valid and out_ready.
- Input accepted when in_valid & in_ready; accepted item appears on out_* exactly SHW advancing cycles later.
- Empty slots (bubbles) propagate as invalid slots and are not compressed.
- Throughput: 1 op per cycle when out_ready is held high.
- Results are never dropped or duplicated; order is preserved.
- Effective amount m = in_k mod WIDTH (low SHW bits). oob = (in_k >= WIDTH).
- ROL: o = x rotated left by m. ROR: o = x rotated right by m. Rotates ignore oob for the data result.
- m=0 returns x unchanged for all ops when oob=0.
- SLL: oob=0 gives x << m with zero fill; oob=1 gives 0.
- SRA: oob=0 gives x >>> m with sign fill; oob=1 gives all bits equal to x[WIDTH-1].
- out_oob is carried with its data through the pipeline.
- in_op and in_k are sampled with in_x at acceptance; later input changes do not affect in-flight items.
- Input ports are don't-care while in_valid=0; no internal state changes except bubbles shifting.
- out_o is held stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain is allowed on the same cycle.
- When out_valid=1 and out_ready=0, in_ready=0 regardless of how many internal slots are empty.
- No X may propagate to out_o from bubble slots: either gate with valid or reset data regs. out_o is only defined while out_valid=1.

Test Plan (WIDTH=32, AMT_W=32, latency 5):
- ROL x=0xC00000C7 k=2 -> out_o=0x0000031F after 5 cycles, oob=0. ROL x=0x000000C7 k=21 -> 0x18E00000.
- ROL k=0 and ROL k=32 with x=0x12345678 -> both 0x12345678; oob 0 then 1. ROL k=35 x=0x0000000F -> 0x00000078, oob=1.
- ROR x=0x0000000A k=3 -> 0x40000001. SLL x=0xFFFFFFFF k=40 -> 0x00000000, oob=1. SLL x=0x1 k=31 -> 0x80000000.
- SRA x=0x80000000 k=31 -> 0xFFFFFFFF. SRA x=0x80000000 k=100 -> 0xFFFFFFFF, oob=1. SRA x=0x7FFFFFFF k=100 -> 0x00000000.
- Backpressure: stream 20 random ops back-to-back with out_ready toggled randomly -> in_ready falls exactly when out_valid & !out_ready, and all 20 results match the software model in order.
- Reset mid-stream: deassert rst_n asynchronously with 3 ops in flight -> out_valid=0 and out_o=0 immediately. After release, a new op completes after 5 cycles with no stale results.

Source files
------------

// File: rtl/barrel_rotate_pipe.sv
// Pipelined rotate/shift unit: one 2^i step per stage, global stall on output backpressure.
// Shift amounts of WIDTH or more saturate SLL/SRA at the input; rotates wrap modulo WIDTH.
module barrel_rotate_pipe #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [AMT_W-1:0] in_k,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_o,
    output logic             out_oob
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    logic             vld_q [SHW];
    logic [WIDTH-1:0] dat_q [SHW];
    logic [SHW-1:0]   amt_q [SHW];
    logic [1:0]       op_q  [SHW];
    logic             oob_q [SHW];

    logic             src_vld [SHW];
    logic [WIDTH-1:0] src_dat [SHW];
    logic [SHW-1:0]   src_amt [SHW];
    logic [1:0]       src_op  [SHW];
    logic             src_oob [SHW];
    logic [WIDTH-1:0] dat_d   [SHW];

    logic             advance;
    logic             in_oob;
    logic [WIDTH-1:0] in_dat;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    generate
        if (AMT_W > SHW) begin : g_oob
            assign in_oob = |in_k[AMT_W-1:SHW];
        end else begin : g_no_oob
            assign in_oob = 1'b0;
        end
    endgenerate

    // Saturated shifts are resolved up front; later stages then shift 0 or all-sign words,
    // which leaves them unchanged.
    always_comb begin
        in_dat = in_x;
        if (in_oob && in_op == OP_SLL) begin
            in_dat = '0;
        end else if (in_oob && in_op == OP_SRA) begin
            in_dat = {WIDTH{in_x[WIDTH-1]}};
        end
    end

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] op, input int s);
        logic signed [WIDTH-1:0] ds;
        logic [WIDTH-1:0]        r;
        ds = d;
        r  = d;
        case (op)
            OP_ROL: r = (d << s) | (d >> (WIDTH - s));
            OP_ROR: r = (d >> s) | (d << (WIDTH - s));
            OP_SLL: r = d << s;
            OP_SRA: r = ds >>> s;
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        src_vld[0] = in_valid;
        src_dat[0] = in_dat;
        src_amt[0] = in_k[SHW-1:0];
        src_op[0]  = in_op;
        src_oob[0] = in_oob;
        for (int i = 1; i < SHW; i++) begin
            src_vld[i] = vld_q[i-1];
            src_dat[i] = dat_q[i-1];
            src_amt[i] = amt_q[i-1];
            src_op[i]  = op_q[i-1];
            src_oob[i] = oob_q[i-1];
        end
        for (int i = 0; i < SHW; i++) begin
            dat_d[i] = src_amt[i][i] ? shift_by(src_dat[i], src_op[i], 1 << i) : src_dat[i];
        end
    end

    // Payload only loads with a valid slot, so bubbles never carry input junk to out_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SHW; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
                amt_q[i] <= '0;
                op_q[i]  <= '0;
                oob_q[i] <= 1'b0;
            end
        end else if (advance) begin
            for (int i = 0; i < SHW; i++) begin
                vld_q[i] <= src_vld[i];
                if (src_vld[i]) begin
                    dat_q[i] <= dat_d[i];
                    amt_q[i] <= src_amt[i];
                    op_q[i]  <= src_op[i];
                    oob_q[i] <= src_oob[i];
                end
            end
        end
    end

    assign out_valid = vld_q[SHW-1];
    assign out_o     = dat_q[SHW-1];
    assign out_oob   = oob_q[SHW-1];
endmodule

// File: tb/tb_barrel_rotate_pipe.sv
// Bench for barrel_rotate_pipe: directed vectors, randomized backpressure stream, reset mid-stream.
module tb_barrel_rotate_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic [31:0] in_k = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_o;
    logic        out_oob;

    int checks = 0;
    int failures = 0;

    barrel_rotate_pipe #(.WIDTH(32), .AMT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_k(in_k), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_o(out_o), .out_oob(out_oob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: rotates built bit by bit from the modular rule, shifts from plain operators.
    function automatic logic [32:0] ref_model(input logic [31:0] x, input logic [31:0] k,
                                              input logic [1:0] op);
        logic [31:0] r;
        logic        oob;
        int          m;
        m   = int'(k % 32);
        oob = (k >= 32);
        r   = '0;
        case (op)
            2'd0: for (int j = 0; j < 32; j++) r[(j + m) % 32] = x[j];
            2'd1: for (int j = 0; j < 32; j++) r[j] = x[(j + m) % 32];
            2'd2: r = oob ? 32'h0 : (x << k);
            default: r = oob ? {32{x[31]}} : 32'($signed(x) >>> k);
        endcase
        return {oob, r};
    endfunction

    typedef struct {
        logic [31:0] x;
        logic [31:0] k;
        logic [1:0]  op;
        logic [31:0] exp_o;
        logic        exp_oob;
    } vec_t;

    vec_t vecs[12];

    // Monitor for the streamed phase: scoreboard plus handshake/stall checks.
    logic        mon_en = 1'b0;
    logic        acc_flag = 1'b0;
    int          drained = 0;
    logic [32:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [32:0] stall_val = '0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            logic [32:0] e;
            chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
            if (stalled && out_valid) chk("stall_hold", {31'd0, out_oob, out_o}, {31'd0, stall_val});
            stalled   = out_valid && !out_ready;
            stall_val = {out_oob, out_o};
            acc_flag  = in_valid && in_ready;
            if (acc_flag) exp_q.push_back(ref_model(in_x, in_k, in_op));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", {31'd0, out_oob, out_o}, {31'd0, e});
                end
                drained++;
            end
        end
    end

    task automatic run_vec(input int idx);
        in_x      = vecs[idx].x;
        in_k      = vecs[idx].k;
        in_op     = vecs[idx].op;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x     = $urandom;
        in_k     = $urandom;
        repeat (3) @(posedge clk);
        #1 chk($sformatf("vec%0d_early", idx), {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_valid", idx), {63'd0, out_valid}, 64'd1);
        chk($sformatf("vec%0d_o", idx), {32'd0, out_o}, {32'd0, vecs[idx].exp_o});
        chk($sformatf("vec%0d_oob", idx), {63'd0, out_oob}, {63'd0, vecs[idx].exp_oob});
    endtask

    initial begin
        int n;
        int cyc;
        int seen;

        vecs[0]  = '{32'hC00000C7, 32'd2,   2'd0, 32'h0000031F, 1'b0};
        vecs[1]  = '{32'h000000C7, 32'd21,  2'd0, 32'h18E00000, 1'b0};
        vecs[2]  = '{32'h12345678, 32'd0,   2'd0, 32'h12345678, 1'b0};
        vecs[3]  = '{32'h12345678, 32'd32,  2'd0, 32'h12345678, 1'b1};
        vecs[4]  = '{32'h0000000F, 32'd35,  2'd0, 32'h00000078, 1'b1};
        vecs[5]  = '{32'h0000000A, 32'd3,   2'd1, 32'h40000001, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'd40,  2'd2, 32'h00000000, 1'b1};
        vecs[7]  = '{32'h00000001, 32'd31,  2'd2, 32'h80000000, 1'b0};
        vecs[8]  = '{32'h80000000, 32'd31,  2'd3, 32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{32'h80000000, 32'd100, 2'd3, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{32'h7FFFFFFF, 32'd100, 2'd3, 32'h00000000, 1'b1};
        vecs[11] = '{32'h89ABCDEF, 32'd0,   2'd3, 32'h89ABCDEF, 1'b0};

        #12;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_o", {32'd0, out_o}, 64'd0);
        chk("rst_oob", {63'd0, out_oob}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_vec(i);
        @(posedge clk); #1;

        // Random stream with random backpressure.
        mon_en    = 1'b1;
        n         = 0;
        in_x      = $urandom;
        in_k      = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
        in_op     = 2'($urandom_range(0, 3));
        in_valid  = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        cyc       = 0;
        while (n < 20 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (acc_flag) begin
                n++;
                if (n < 20) begin
                    in_x  = $urandom;
                    in_k  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
                    in_op = 2'($urandom_range(0, 3));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        chk("stream_accepted", 64'(n), 64'd20);
        in_valid = 1'b0;
        cyc = 0;
        while (drained < 20 && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            cyc++;
        end
        chk("stream_drained", 64'(drained), 64'd20);
        chk("stream_queue_empty", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;

        // Reset with three operations in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_x     = 32'h00010000 << i;
            in_k     = 32'd1;
            in_op    = 2'd0;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_o", {32'd0, out_o}, 64'd0);
        chk("midrst_oob", {63'd0, out_oob}, 64'd0);
        #3 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_stale", 64'(seen), 64'd0);
        run_vec(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
